// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register index and data word widths, plus the
// hard-wired zero register index used by decode, write-back and the register file.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] regaddr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam regaddr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// Per-register scoreboard counter: counts writes that have been issued but not
// yet written back. Saturates at both ends and flags the offending event.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Count reservations up and write-backs down; a simultaneous pair cancels
    // out (the write retires the older reservation). Overflow holds at max,
    // underflow holds at zero; either one latches the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_cnt == CNT_MAX) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_cnt == '0) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = r_err;
endmodule

// File: rtl/reg_file_sb.sv
// 32-entry register file with write-through read bypass and a per-register
// pending-write scoreboard. Decode reads two operands with busy flags; issue
// reserves a destination; write-back commits data and releases the reservation.
module reg_file_sb #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic              err
);
    import cpu_pkg::*;

    localparam int NREG = 2 ** ADDR_W;

    // Register 0 is hard-wired: writes and reservations aimed at it are dropped
    // here so neither the array nor the scoreboard ever sees them.
    logic w_wr;
    logic w_rsv;
    assign w_wr  = we && (wa != REG_ZERO);
    assign w_rsv = rsv_en && (rsv_addr != REG_ZERO);

    logic [DATA_W-1:0] r_regs [1:NREG-1];
    logic [DATA_W-1:0] w_regs [NREG];
    logic [CNT_W-1:0]  w_cnt  [NREG];
    logic [NREG-1:0]   w_err;

    assign w_regs[0] = '0;
    assign w_cnt[0]  = '0;
    assign w_err[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            // Commit write-back data; cleared on reset, so a write in the
            // reset cycle is lost.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[gi] <= '0;
                end else if (w_wr && (wa == ADDR_W'(gi))) begin
                    r_regs[gi] <= wd;
                end
            end

            assign w_regs[gi] = r_regs[gi];

            sb_counter #(
                .CNT_W (CNT_W)
            ) u_sb_counter (
                .clk   (clk),
                .rst_n (rst_n),
                .i_inc (w_rsv && (rsv_addr == ADDR_W'(gi))),
                .i_dec (w_wr && (wa == ADDR_W'(gi))),
                .o_cnt (w_cnt[gi]),
                .o_err (w_err[gi])
            );
        end
    endgenerate

    // Operand read with same-cycle forwarding of the write-back data; w_wr
    // already excludes register 0, so r0 always reads as zero.
    always_comb begin
        rd1 = w_regs[ra1];
        rd2 = w_regs[ra2];
        if (w_wr && (wa == ra1)) begin
            rd1 = wd;
        end
        if (w_wr && (wa == ra2)) begin
            rd2 = wd;
        end
    end

    // Busy while writes are outstanding, except when the last one is being
    // written back this very cycle. Same-cycle reservations show up next cycle.
    always_comb begin
        busy1 = (w_cnt[ra1] != '0) &&
                !(we && (wa == ra1) && (w_cnt[ra1] == CNT_W'(1)));
        busy2 = (w_cnt[ra2] != '0) &&
                !(we && (wa == ra2) && (w_cnt[ra2] == CNT_W'(1)));
    end

    assign err = |w_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed-vector bench for reg_file_sb: reset, bypass, reservation/busy timing,
// multiple outstanding writes, same-cycle reserve+write, r0 handling, overflow
// and an asynchronous mid-cycle reset.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, rsv_addr, wa;
    logic [31:0] rd1, rd2, wd;
    logic        busy1, busy2, rsv_en, we, err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .busy1    (busy1),
        .busy2    (busy2),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .err      (err)
    );

    // Advance to just after the next rising edge; stimulus is applied there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; we = 1'b0; rsv_en = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; rsv_en = 1'b0; wa = 5'd0; wd = '0; rsv_addr = 5'd0;
        ra1 = 5'd5; ra2 = 5'd0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_rd1 got=%h exp=%h", rd1, 32'h0); end
        n_vec++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL reset_rd2 got=%h exp=%h", rd2, 32'h0); end
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
        n_vec++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        $display("test_reset done");
        tick();
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra1 = 5'd3;
        @(negedge clk);
        n_vec++; if (rd1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_rd1 got=%h exp=%h", rd1, 32'hDEADBEEF); end
        tick();
        we = 1'b0; wd = 32'h0; ra2 = 5'd3;
        @(negedge clk);
        n_vec++; if (rd1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_rd1 got=%h exp=%h", rd1, 32'hDEADBEEF); end
        n_vec++; if (rd2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_rd2 got=%h exp=%h", rd2, 32'hDEADBEEF); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL underflow_err got=%b exp=1", err); end
        $display("test_bypass done");
        tick();
    endtask

    task automatic test_reserve();
        pulse_reset();
        rsv_en = 1'b1; rsv_addr = 5'd7; ra1 = 5'd7;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rsv_same_cycle_busy1 got=%b exp=0", busy1); end
        tick();
        rsv_en = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_vec++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL rsv_busy1_cyc%0d got=%b exp=1", c, busy1); end
            tick();
        end
        we = 1'b1; wa = 5'd7; wd = 32'h12;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL wb_busy1 got=%b exp=0", busy1); end
        n_vec++; if (rd1 !== 32'h12) begin n_bad++; $display("FAIL wb_rd1 got=%h exp=%h", rd1, 32'h12); end
        tick();
        we = 1'b0;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL after_wb_busy1 got=%b exp=0", busy1); end
        n_vec++; if (rd1 !== 32'h12) begin n_bad++; $display("FAIL after_wb_rd1 got=%h exp=%h", rd1, 32'h12); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reserve_err got=%b exp=0", err); end
        $display("test_reserve done");
        tick();
    endtask

    task automatic test_multi();
        ra2 = 5'd9; rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        tick();
        rsv_en = 1'b0; we = 1'b1; wa = 5'd9; wd = 32'h99;
        @(negedge clk);
        n_vec++; if (busy2 !== 1'b1) begin n_bad++; $display("FAIL multi_first_wb_busy2 got=%b exp=1", busy2); end
        tick();
        wd = 32'h9A;
        @(negedge clk);
        n_vec++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL multi_last_wb_busy2 got=%b exp=0", busy2); end
        n_vec++; if (rd2 !== 32'h9A) begin n_bad++; $display("FAIL multi_last_wb_rd2 got=%h exp=%h", rd2, 32'h9A); end
        tick();
        we = 1'b0;
        @(negedge clk);
        n_vec++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL multi_idle_busy2 got=%b exp=0", busy2); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL multi_err got=%b exp=0", err); end
        $display("test_multi done");
        tick();
    endtask

    task automatic test_same_cycle();
        ra1 = 5'd4; rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        we = 1'b1; wa = 5'd4; wd = 32'h44;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL same_cycle_busy1 got=%b exp=0", busy1); end
        n_vec++; if (rd1 !== 32'h44) begin n_bad++; $display("FAIL same_cycle_rd1 got=%h exp=%h", rd1, 32'h44); end
        tick();
        rsv_en = 1'b0; we = 1'b0;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL same_cycle_next_busy1 got=%b exp=1", busy1); end
        n_vec++; if (rd1 !== 32'h44) begin n_bad++; $display("FAIL same_cycle_next_rd1 got=%h exp=%h", rd1, 32'h44); end
        tick();
        we = 1'b1; wd = 32'h45;
        tick();
        we = 1'b0;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL same_cycle_retire_busy1 got=%b exp=0", busy1); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL same_cycle_err got=%b exp=0", err); end
        $display("test_same_cycle done");
        tick();
    endtask

    task automatic test_r0_overflow();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF; rsv_en = 1'b1; rsv_addr = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
        @(negedge clk);
        n_vec++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL r0_bypass_rd1 got=%h exp=%h", rd1, 32'h0); end
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL r0_busy1 got=%b exp=0", busy1); end
        tick();
        we = 1'b0; rsv_en = 1'b0;
        @(negedge clk);
        n_vec++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL r0_rd2 got=%h exp=%h", rd2, 32'h0); end
        n_vec++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL r0_busy2 got=%b exp=0", busy2); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL r0_err got=%b exp=0", err); end
        tick();
        ra1 = 5'd2; rsv_en = 1'b1; rsv_addr = 5'd2;
        tick(); tick(); tick();
        rsv_en = 1'b0;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL full_busy1 got=%b exp=1", busy1); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err got=%b exp=0", err); end
        tick();
        rsv_en = 1'b1;
        tick();
        rsv_en = 1'b0;
        @(negedge clk);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL overflow_err got=%b exp=1", err); end
        tick(); tick();
        @(negedge clk);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL overflow_sticky_err got=%b exp=1", err); end
        tick();
        we = 1'b1; wa = 5'd2; wd = 32'h22;
        tick(); tick();
        we = 1'b0;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL saturate_busy1 got=%b exp=1", busy1); end
        tick();
        we = 1'b1; wd = 32'h23;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL saturate_last_busy1 got=%b exp=0", busy1); end
        tick();
        wa = 5'd3; wd = 32'hA5A5;
        tick();
        // Reserve r5 and write r6, then assert reset in the middle of the cycle
        rsv_en = 1'b1; rsv_addr = 5'd5; wa = 5'd6; wd = 32'h66;
        #2 rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1; rsv_en = 1'b0; we = 1'b0; ra1 = 5'd3; ra2 = 5'd6;
        #1;
        n_vec++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL midrst_r3 got=%h exp=%h", rd1, 32'h0); end
        n_vec++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL midrst_r6 got=%h exp=%h", rd2, 32'h0); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b exp=0", err); end
        tick();
        ra1 = 5'd5; ra2 = 5'd2;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_r5 got=%b exp=0", busy1); end
        n_vec++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_r2 got=%b exp=0", busy2); end
        n_vec++; if (rd2 !== 32'h0) begin n_bad++; $display("FAIL midrst_r2 got=%h exp=%h", rd2, 32'h0); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err_later got=%b exp=0", err); end
        $display("test_r0_overflow done");
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_reserve();
        test_multi();
        test_same_cycle();
        test_r0_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
